// File: rtl/xm_bus_master.sv
// Wishbone-classic bus master for the XM core: posted in-order write buffer,
// read-after-drain ordering, byte-lane steering, and timeout/bus-error reporting.
module xm_bus_master #(
  parameter int WORD       = 16,
  parameter int WBUF_DEPTH = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                                clk_i,
  input  logic                                arst_i,
  input  logic                                en_i,
  input  logic                                rw_i,
  input  logic                                byte_i,
  input  logic [WORD-1:0]                     addr_i,
  input  logic [WORD-1:0]                     data_i,
  output logic                                busy_o,
  output logic                                done_o,
  output logic [WORD-1:0]                     data_o,
  output logic                                err_o,
  output logic [WORD-1:0]                     fault_adr_o,
  input  logic                                ack_i,
  input  logic                                err_i,
  input  logic [WORD-1:0]                     dat_i,
  output logic                                we_o,
  output logic                                stb_o,
  output logic                                cyc_o,
  output logic [WORD/8-1:0]                   sel_o,
  output logic [WORD-$clog2(WORD/8)-1:0]      adr_o,
  output logic [WORD-1:0]                     dat_o
);

  localparam int NB = WORD / 8;
  localparam int LB = $clog2(NB);
  localparam int AW = WORD - LB;
  localparam int PW = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int CW = $clog2(WBUF_DEPTH + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  state_t            r_state, w_next;
  logic [AW-1:0]     r_fadr [WBUF_DEPTH];
  logic [NB-1:0]     r_fsel [WBUF_DEPTH];
  logic [WORD-1:0]   r_fdat [WBUF_DEPTH];
  logic [PW-1:0]     r_wp, r_rp;
  logic [CW-1:0]     r_cnt;
  logic              r_rd_pend, r_rbyte;
  logic [AW-1:0]     r_radr;
  logic [NB-1:0]     r_rsel;
  logic [TW-1:0]     r_tmo;
  logic              r_done, r_err;
  logic [WORD-1:0]   r_data, r_fault;

  logic              w_full, w_empty, w_accept, w_misal, w_push, w_rd_acc;
  logic              w_on_bus, w_term, w_tmo, w_fault, w_ok, w_pop;
  logic [NB-1:0]     w_req_sel, w_cur_sel;
  logic [WORD-1:0]   w_req_dat;
  logic [AW-1:0]     w_cur_adr;

  function automatic logic [LB-1:0] f_low_lane(input logic [NB-1:0] sel);
    f_low_lane = '0;
    for (int i = NB - 1; i >= 0; i--)
      if (sel[i]) f_low_lane = LB'(i);
  endfunction

  function automatic logic [WORD-1:0] f_lane(input logic [WORD-1:0] d, input logic [LB-1:0] l);
    logic [WORD-1:0] s;
    s = d >> {l, 3'b000};
    f_lane = {{(WORD-8){1'b0}}, s[7:0]};
  endfunction

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    f_inc = (p == PW'(WBUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_full   = (r_cnt == CW'(WBUF_DEPTH));
  assign w_empty  = (r_cnt == '0);
  assign busy_o   = r_rd_pend | w_full;
  assign w_accept = en_i & ~busy_o;
  assign w_misal  = ~byte_i & (addr_i[LB-1:0] != '0);
  assign w_push   = w_accept & ~w_misal & rw_i;
  assign w_rd_acc = w_accept & ~w_misal & ~rw_i;
  assign w_req_dat = byte_i ? {NB{data_i[7:0]}} : data_i;

  always_comb begin
    w_req_sel = '1;
    if (byte_i) w_req_sel = NB'(1) << addr_i[LB-1:0];
  end

  assign w_on_bus  = (r_state != IDLE);
  assign w_cur_adr = (r_state == WR) ? r_fadr[r_rp] : r_radr;
  assign w_cur_sel = (r_state == WR) ? r_fsel[r_rp] : r_rsel;
  assign w_term    = ack_i | err_i;
  // Abort on the TIMEOUT-th strobe cycle only if the slave has not terminated it.
  assign w_tmo     = (TIMEOUT != 0) && w_on_bus && !w_term && (r_tmo == TW'(TIMEOUT - 1));
  assign w_fault   = w_on_bus && (err_i || w_tmo);
  assign w_ok      = w_on_bus && ack_i && !err_i;
  assign w_pop     = (r_state == WR) && (w_term || w_tmo);

  assign cyc_o       = w_on_bus;
  assign stb_o       = w_on_bus;
  assign we_o        = (r_state == WR);
  assign adr_o       = w_on_bus ? w_cur_adr : '0;
  assign sel_o       = w_on_bus ? w_cur_sel : '0;
  assign dat_o       = (r_state == WR) ? r_fdat[r_rp] : '0;
  assign done_o      = r_done;
  assign err_o       = r_err;
  assign data_o      = r_data;
  assign fault_adr_o = r_fault;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (!w_empty) w_next = WR;
               else if (r_rd_pend) w_next = RD;
      WR, RD:  if (w_term || w_tmo) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      r_state   <= IDLE;
      r_wp      <= '0;
      r_rp      <= '0;
      r_cnt     <= '0;
      r_rd_pend <= 1'b0;
      r_tmo     <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_data    <= '0;
      r_fault   <= '0;
    end else begin
      r_state <= w_next;
      if (w_push) r_wp <= f_inc(r_wp);
      if (w_pop)  r_rp <= f_inc(r_rp);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
      if (w_rd_acc) r_rd_pend <= 1'b1;
      else if ((r_state == RD) && (w_term || w_tmo)) r_rd_pend <= 1'b0;
      r_tmo  <= (!w_on_bus || w_term) ? '0 : r_tmo + 1'b1;
      r_done <= (r_state == RD) && w_ok;
      if ((r_state == RD) && w_ok) r_data <= r_rbyte ? f_lane(dat_i, f_low_lane(r_rsel)) : dat_i;
      r_err <= w_fault | (w_accept & w_misal);
      if (w_fault) r_fault <= {w_cur_adr, f_low_lane(w_cur_sel)};
      else if (w_accept & w_misal) r_fault <= addr_i;
    end
  end

  // Payload storage carries no reset; validity is tracked by r_cnt and r_rd_pend.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fadr[r_wp] <= addr_i[WORD-1:LB];
      r_fsel[r_wp] <= w_req_sel;
      r_fdat[r_wp] <= w_req_dat;
    end
    if (w_rd_acc) begin
      r_radr  <= addr_i[WORD-1:LB];
      r_rsel  <= w_req_sel;
      r_rbyte <= byte_i;
    end
  end

endmodule

// File: tb/tb_xm_bus_master.sv
// Scoreboard bench for xm_bus_master: expected bus cycles and core responses are
// queued by the stimulus thread and consumed by an independent monitor.
module tb_xm_bus_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst_n;
  logic        en, rw, bt;
  logic [15:0] addr, wdata;
  logic        busy, done, errp;
  logic [15:0] rdata, fadr;
  logic        ack, berr;
  logic [15:0] dat_in;
  logic        we, stb, cyc;
  logic [1:0]  sel;
  logic [14:0] adr;
  logic [15:0] dat_out;

  logic        en32, rw32, bt32;
  logic [31:0] addr32, wdata32;
  logic        busy32, done32, err32o;
  logic [31:0] rdata32, fadr32;
  logic        ack32, berr32;
  logic [31:0] dat_in32;
  logic        we32, stb32, cyc32;
  logic [3:0]  sel32;
  logic [29:0] adr32;
  logic [31:0] dat_out32;

  xm_bus_master #(.WORD(16), .WBUF_DEPTH(2), .TIMEOUT(4)) dut (
    .clk_i(clk), .arst_i(arst_n), .en_i(en), .rw_i(rw), .byte_i(bt),
    .addr_i(addr), .data_i(wdata), .busy_o(busy), .done_o(done),
    .data_o(rdata), .err_o(errp), .fault_adr_o(fadr), .ack_i(ack),
    .err_i(berr), .dat_i(dat_in), .we_o(we), .stb_o(stb), .cyc_o(cyc),
    .sel_o(sel), .adr_o(adr), .dat_o(dat_out)
  );

  xm_bus_master #(.WORD(32), .WBUF_DEPTH(2), .TIMEOUT(255)) dut32 (
    .clk_i(clk), .arst_i(arst_n), .en_i(en32), .rw_i(rw32), .byte_i(bt32),
    .addr_i(addr32), .data_i(wdata32), .busy_o(busy32), .done_o(done32),
    .data_o(rdata32), .err_o(err32o), .fault_adr_o(fadr32), .ack_i(ack32),
    .err_i(berr32), .dat_i(dat_in32), .we_o(we32), .stb_o(stb32), .cyc_o(cyc32),
    .sel_o(sel32), .adr_o(adr32), .dat_o(dat_out32)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {bit we; logic [15:0] adr; logic [1:0] sel; logic [15:0] dat;} bus_t;
  typedef struct {bit is_err; logic [15:0] val;} rsp_t;
  bus_t bus_q[$];
  rsp_t rsp_q[$];

  typedef enum int {M_ACK, M_ERR, M_BOTH, M_NONE} mode_t;
  mode_t mode = M_ACK;
  int    dly  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_bus(input bit w, input logic [15:0] a, input logic [1:0] s, input logic [15:0] d);
    bus_t b;
    b.we = w; b.adr = a; b.sel = s; b.dat = d;
    bus_q.push_back(b);
  endtask

  task automatic push_rsp(input bit e, input logic [15:0] v);
    rsp_t r;
    r.is_err = e; r.val = v;
    rsp_q.push_back(r);
  endtask

  task automatic req(input bit w, input bit b, input logic [15:0] a, input logic [15:0] d, input bit exp_acc);
    @(negedge clk);
    chk("busy_at_request", busy, !exp_acc);
    en = 1'b1; rw = w; bt = b; addr = a; wdata = d;
    @(posedge clk);
    #1 en = 1'b0;
  endtask

  task automatic wait_not_busy();
    int n = 0;
    while (busy && n < 50) begin @(negedge clk); n++; end
    if (busy) chk("wait_busy_timeout", busy, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((cyc || busy) && n < 60) begin @(negedge clk); n++; end
    if (cyc || busy) chk("wait_idle_timeout", {cyc, busy}, 0);
    repeat (2) @(negedge clk);
  endtask

  // Slave model: terminates the cycle after 'dly' strobe cycles according to 'mode'.
  initial begin
    int scnt = 0;
    ack = 1'b0; berr = 1'b0;
    forever begin
      @(negedge clk);
      if (!stb) begin
        ack = 1'b0; berr = 1'b0; scnt = 0;
      end else begin
        ack  = (mode == M_ACK || mode == M_BOTH) && (scnt == dly);
        berr = (mode == M_ERR || mode == M_BOTH) && (scnt == dly);
        scnt++;
      end
    end
  end

  // Monitor: one expected bus cycle per stb rise, one expected response per done/err pulse.
  initial begin
    bit prev = 1'b0;
    bus_t b;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (!arst_n) begin
        prev = 1'b0;
      end else begin
        if (stb && !prev) begin
          if (bus_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL bus_unexpected: adr 0x%0h we %0d with no cycle expected", adr, we);
          end else begin
            b = bus_q.pop_front();
            chk("bus_we", we, b.we);
            chk("bus_adr", adr, b.adr);
            chk("bus_sel", sel, b.sel);
            chk("bus_cyc", cyc, 1);
            if (b.we) chk("bus_dat", dat_out, b.dat);
          end
        end
        prev = stb;
        if (done || errp) begin
          if (rsp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL rsp_unexpected: done %0d err %0d with no response expected", done, errp);
          end else begin
            r = rsp_q.pop_front();
            chk("rsp_kind_err", errp, r.is_err);
            chk("rsp_kind_done", done, !r.is_err);
            if (r.is_err) chk("rsp_fault_adr", fadr, r.val);
            else          chk("rsp_data", rdata, r.val);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    arst_n = 1'b0;
    en = 0; rw = 0; bt = 0; addr = '0; wdata = '0; dat_in = '0;
    en32 = 0; rw32 = 0; bt32 = 0; addr32 = '0; wdata32 = '0;
    ack32 = 1'b1; berr32 = 1'b0; dat_in32 = '0;
    repeat (3) @(negedge clk);
    chk("rst_cyc", cyc, 0);
    chk("rst_stb", stb, 0);
    chk("rst_we", we, 0);
    chk("rst_sel", sel, 0);
    chk("rst_adr", adr, 0);
    chk("rst_dat_o", dat_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", errp, 0);
    chk("rst_data_o", rdata, 0);
    chk("rst_fault_adr", fadr, 0);
    chk("rst_cyc32", cyc32, 0);
    arst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Word write, zero-wait slave.
    mode = M_ACK; dly = 0;
    push_bus(1, 16'h0008, 2'b11, 16'hBEEF);
    req(1, 0, 16'h0010, 16'hBEEF, 1);
    @(negedge clk); chk("wr_stb_after_e0", stb, 0); chk("wr_busy_e0", busy, 0);
    @(negedge clk); chk("wr_stb_after_e1", stb, 1); chk("wr_busy_e1", busy, 0);
    @(negedge clk); chk("wr_stb_after_e2", stb, 0); chk("wr_busy_e2", busy, 0);
    wait_idle();

    // Byte read from the upper lane.
    dat_in = 16'hA55A;
    push_bus(0, 16'h0009, 2'b10, 16'h0000);
    push_rsp(0, 16'h00A5);
    req(0, 1, 16'h0013, 16'h0000, 1);
    @(negedge clk); chk("rd_done_e0", done, 0); chk("rd_busy_pending", busy, 1);
    @(negedge clk); chk("rd_done_e1", done, 0);
    @(negedge clk); chk("rd_done_e2", done, 1); chk("rd_busy_after_done", busy, 0);
    @(negedge clk); chk("rd_done_single", done, 0);
    wait_idle();

    // Buffer fill: third write dropped, read ordered behind both writes.
    dly = 3; dat_in = 16'h1234;
    push_bus(1, 16'h0080, 2'b11, 16'h1111);
    push_bus(1, 16'h0081, 2'b11, 16'h2222);
    push_bus(0, 16'h0083, 2'b11, 16'h0000);
    push_rsp(0, 16'h1234);
    req(1, 0, 16'h0100, 16'h1111, 1);
    req(1, 0, 16'h0102, 16'h2222, 1);
    req(1, 0, 16'h0104, 16'h3333, 0);
    wait_not_busy();
    req(0, 0, 16'h0106, 16'h0000, 1);
    wait_idle();

    // Misaligned word read.
    dly = 0;
    push_rsp(1, 16'h0021);
    req(0, 0, 16'h0021, 16'h0000, 1);
    @(negedge clk); chk("mis_err", errp, 1); chk("mis_busy", busy, 0); chk("mis_cyc", cyc, 0);
    @(negedge clk); chk("mis_err_single", errp, 0);
    wait_idle();

    // Bus error on a byte write reports the lane's byte address.
    mode = M_ERR; dly = 1;
    push_bus(1, 16'h0019, 2'b10, 16'h7777);
    push_rsp(1, 16'h0033);
    req(1, 1, 16'h0033, 16'h0077, 1);
    wait_idle();

    // ack and err together: err wins, no done.
    mode = M_BOTH; dly = 0;
    push_bus(0, 16'h0030, 2'b11, 16'h0000);
    push_rsp(1, 16'h0060);
    req(0, 0, 16'h0060, 16'h0000, 1);
    wait_idle();

    // Timeout on a read with no terminate, then a normal write.
    mode = M_NONE;
    push_bus(0, 16'h0020, 2'b11, 16'h0000);
    push_rsp(1, 16'h0040);
    req(0, 0, 16'h0040, 16'h0000, 1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (stb) n++;
      else if (n > 0) break;
    end
    chk("tmo_stb_cycles", n, 4);
    chk("tmo_no_done", done, 0);
    mode = M_ACK;
    push_bus(1, 16'h0028, 2'b11, 16'h5A5A);
    req(1, 0, 16'h0050, 16'h5A5A, 1);
    wait_idle();

    // Asynchronous reset during a write cycle with two entries buffered.
    mode = M_NONE;
    push_bus(1, 16'h0038, 2'b11, 16'h7070);
    req(1, 0, 16'h0070, 16'h7070, 1);
    req(1, 0, 16'h0072, 16'h7272, 1);
    @(negedge clk);
    chk("rst_mid_pre_stb", stb, 1);
    #2 arst_n = 1'b0;
    #1;
    chk("rst_mid_cyc", cyc, 0);
    chk("rst_mid_stb", stb, 0);
    chk("rst_mid_busy", busy, 0);
    @(negedge clk);
    #2 arst_n = 1'b1;
    mode = M_ACK;
    repeat (8) @(negedge clk);
    chk("rst_after_cyc", cyc, 0);
    chk("rst_after_busy", busy, 0);

    // 32-bit instance: byte write replicates data on all lanes.
    @(negedge clk);
    en32 = 1'b1; rw32 = 1'b1; bt32 = 1'b1; addr32 = 32'h0000_0102; wdata32 = 32'h0000_007C;
    @(posedge clk);
    #1 en32 = 1'b0;
    @(negedge clk); chk("w32_stb_e0", stb32, 0);
    @(negedge clk);
    chk("w32_stb", stb32, 1);
    chk("w32_we", we32, 1);
    chk("w32_sel", sel32, 4'b0100);
    chk("w32_dat", dat_out32, 32'h7C7C7C7C);
    chk("w32_adr", adr32, 30'h40);
    @(negedge clk); chk("w32_stb_end", stb32, 0); chk("w32_busy", busy32, 0);

    n = 0;
    while ((bus_q.size() != 0 || rsp_q.size() != 0) && n < 50) begin @(negedge clk); n++; end
    chk("bus_q_left", bus_q.size(), 0);
    chk("rsp_q_left", rsp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
